// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch stage bus: imem request channel, redirect input and decode handshake
// master: fetch_queue side (drives imem_req/imem_addr and the decode head outputs)
// slave : environment side (memory, branch unit, decode)
interface fetch_queue_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16
);
    logic               halt;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;
    logic [3:0]         count;
    logic               full;

    modport master (
        input  halt, imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, count, full
    );

    modport slave (
        output halt, imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, count, full
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch/prefetch queue with redirect flush
// clock : rising-edge clock
// reset : asynchronous active-low reset
// bus   : fetch_queue_if.master
//         halt                          - blocks new requests, in-flight one completes
//         imem_req/imem_addr/imem_ack/imem_rdata - single-outstanding memory request
//         redirect_valid/redirect_pc    - taken jump/branch, flushes queue
//         instr_valid/instr/instr_pc/instr_ready - head entry handshake to decode
//         count/full                    - FIFO occupancy
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16
) (
    input  logic          clock,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = ADDR_W + INSTR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]         count_q, count_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];

    logic               push;
    logic               pop;
    logic [3:0]         count_after;

    // A redirect on the same edge cancels both the push and the pop.
    assign push        = (state_q == REQ) && bus.imem_ack && !bus.redirect_valid;
    assign pop         = (count_q != 4'd0) && bus.instr_ready && !bus.redirect_valid;
    assign count_after = count_q + 4'(push) - 4'(pop);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            req_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage needs no reset: outputs are gated by count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_addr_q, bus.imem_rdata};
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_after;

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end

        case (state_q)
            IDLE: begin
                if (!bus.redirect_valid && !bus.halt && (count_q < 4'(DEPTH))) begin
                    state_d    = REQ;
                    req_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (bus.redirect_valid) begin
                    // Without an ack the memory still owes us a word; absorb it in DROP.
                    state_d = bus.imem_ack ? IDLE : DROP;
                end else if (bus.imem_ack) begin
                    fetch_pc_d = fetch_pc_q + 1'b1;
                    if (!bus.halt && (count_after < 4'(DEPTH))) begin
                        req_addr_d = fetch_pc_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                // Request address stays on the old target until the stale ack arrives.
                if (bus.imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.imem_req    = (state_q != IDLE);
        bus.imem_addr   = req_addr_q;
        bus.instr_valid = (count_q != 4'd0);
        bus.count       = count_q;
        bus.full        = (count_q == 4'(DEPTH));
        if (count_q != 4'd0) begin
            {bus.instr_pc, bus.instr} = mem_q[rd_ptr_q];
        end else begin
            bus.instr_pc = '0;
            bus.instr    = '0;
        end
    end
endmodule
